// File: rtl/vc_link_tx.sv
// Two-VC credit-based link transmitter: round-robin arbitration between VC0/VC1
// gated by per-VC downstream credits, with a registered single-flit output stage.
module vc_link_tx #(
  parameter int CREDITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] vc0_flit,
  input  logic       vc0_valid,
  output logic       vc0_ready,
  input  logic [7:0] vc1_flit,
  input  logic       vc1_valid,
  output logic       vc1_ready,
  output logic [7:0] flit_out,
  output logic       vc_sel,
  output logic       flit_valid,
  input  logic       credit_in,
  input  logic       credit_vc,
  output logic [2:0] vc0_credits,
  output logic [2:0] vc1_credits,
  output logic       credit_err
);

  localparam logic [2:0] CRED_FULL_C = 3'(CREDITS);

  logic [2:0] vc0_cnt_r;
  logic [2:0] vc1_cnt_r;
  logic       last_grant_r;
  logic [7:0] flit_r;
  logic       vc_sel_r;
  logic       flit_valid_r;
  logic       credit_err_r;

  logic       elig0_s;
  logic       elig1_s;
  logic       grant0_s;
  logic       grant1_s;
  logic       give0_s;
  logic       give1_s;
  logic [3:0] vc0_next_s;
  logic [3:0] vc1_next_s;

  // Returns {overflow, next_count}; a simultaneous take and give cancel out.
  function automatic logic [3:0] credit_next(input logic [2:0] cnt,
                                             input logic       take,
                                             input logic       give);
    logic [3:0] res;
    case ({take, give})
      2'b10: res = {1'b0, cnt - 3'd1};
      2'b01: begin
        if (cnt == CRED_FULL_C) begin
          res = {1'b1, cnt};
        end else begin
          res = {1'b0, cnt + 3'd1};
        end
      end
      default: res = {1'b0, cnt};
    endcase
    return res;
  endfunction

  // Eligibility, round-robin grant and credit-return decode.
  always_comb begin
    elig0_s  = rst & vc0_valid & (vc0_cnt_r != 3'd0);
    elig1_s  = rst & vc1_valid & (vc1_cnt_r != 3'd0);
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (elig0_s && elig1_s) begin
      // Contention goes to the VC that did not win last time.
      if (last_grant_r) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = 1'b1;
      end
    end else begin
      grant0_s = elig0_s;
      grant1_s = elig1_s;
    end
    give0_s    = credit_in & ~credit_vc;
    give1_s    = credit_in & credit_vc;
    vc0_next_s = credit_next(vc0_cnt_r, grant0_s, give0_s);
    vc1_next_s = credit_next(vc1_cnt_r, grant1_s, give1_s);
  end

  // Credit counters, sticky overflow flag, arbiter pointer and output flit stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vc0_cnt_r    <= CRED_FULL_C;
      vc1_cnt_r    <= CRED_FULL_C;
      last_grant_r <= 1'b1;
      flit_r       <= 8'h00;
      vc_sel_r     <= 1'b0;
      flit_valid_r <= 1'b0;
      credit_err_r <= 1'b0;
    end else begin
      vc0_cnt_r    <= vc0_next_s[2:0];
      vc1_cnt_r    <= vc1_next_s[2:0];
      credit_err_r <= credit_err_r | vc0_next_s[3] | vc1_next_s[3];
      if (grant0_s || grant1_s) begin
        flit_r       <= grant1_s ? vc1_flit : vc0_flit;
        vc_sel_r     <= grant1_s;
        last_grant_r <= grant1_s;
        flit_valid_r <= 1'b1;
      end else begin
        flit_valid_r <= 1'b0;
      end
    end
  end

  assign vc0_ready   = grant0_s;
  assign vc1_ready   = grant1_s;
  assign flit_out    = flit_r;
  assign vc_sel      = vc_sel_r;
  assign flit_valid  = flit_valid_r;
  assign vc0_credits = vc0_cnt_r;
  assign vc1_credits = vc1_cnt_r;
  assign credit_err  = credit_err_r;

endmodule

// File: tb/tb_vc_link_tx.sv
// Self-checking bench for vc_link_tx: directed scenarios plus randomized traffic
// against a cycle-level reference model of arbitration, credits and output flits.
module tb_vc_link_tx;

  localparam int CREDITS = 2;

  logic       clk;
  logic       rst;
  logic [7:0] vc0_flit;
  logic       vc0_valid;
  logic       vc0_ready;
  logic [7:0] vc1_flit;
  logic       vc1_valid;
  logic       vc1_ready;
  logic [7:0] flit_out;
  logic       vc_sel;
  logic       flit_valid;
  logic       credit_in;
  logic       credit_vc;
  logic [2:0] vc0_credits;
  logic [2:0] vc1_credits;
  logic       credit_err;

  int checks;
  int failures;

  // Reference model state
  int         m_c0;
  int         m_c1;
  int         m_last;
  logic       m_fv;
  logic [7:0] m_fo;
  logic       m_sel;
  logic       m_err;
  logic       exp_r0;
  logic       exp_r1;
  logic       act_r0;
  logic       act_r1;

  vc_link_tx #(.CREDITS(CREDITS)) dut (
    .clk(clk), .rst(rst),
    .vc0_flit(vc0_flit), .vc0_valid(vc0_valid), .vc0_ready(vc0_ready),
    .vc1_flit(vc1_flit), .vc1_valid(vc1_valid), .vc1_ready(vc1_ready),
    .flit_out(flit_out), .vc_sel(vc_sel), .flit_valid(flit_valid),
    .credit_in(credit_in), .credit_vc(credit_vc),
    .vc0_credits(vc0_credits), .vc1_credits(vc1_credits), .credit_err(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_c0 = CREDITS; m_c1 = CREDITS; m_last = 1;
    m_fv = 1'b0; m_fo = 8'h00; m_sel = 1'b0; m_err = 1'b0;
  endtask

  task automatic set_idle();
    vc0_valid = 1'b0; vc1_valid = 1'b0; vc0_flit = 8'h00; vc1_flit = 8'h00;
    credit_in = 1'b0; credit_vc = 1'b0;
  endtask

  // One clock cycle: apply inputs, sample readies at negedge, advance model after posedge.
  task automatic drive(input logic v0, input logic [7:0] f0, input logic v1,
                       input logic [7:0] f1, input logic ci, input logic cv);
    logic e0, e1, g0, g1;
    vc0_valid = v0; vc0_flit = f0; vc1_valid = v1; vc1_flit = f1;
    credit_in = ci; credit_vc = cv;
    @(negedge clk);
    act_r0 = vc0_ready; act_r1 = vc1_ready;
    e0 = v0 && (m_c0 > 0);
    e1 = v1 && (m_c1 > 0);
    g0 = e0 && (!e1 || m_last == 1);
    g1 = e1 && !g0;
    exp_r0 = g0; exp_r1 = g1;
    @(posedge clk); #1;
    if (g0 || g1) begin
      m_fv = 1'b1; m_fo = g1 ? f1 : f0; m_sel = g1; m_last = g1 ? 1 : 0;
    end else begin
      m_fv = 1'b0;
    end
    m_c0 = m_c0 - (g0 ? 1 : 0) + ((ci && !cv) ? 1 : 0);
    m_c1 = m_c1 - (g1 ? 1 : 0) + ((ci && cv) ? 1 : 0);
    if (m_c0 > CREDITS) begin m_c0 = CREDITS; m_err = 1'b1; end
    if (m_c1 > CREDITS) begin m_c1 = CREDITS; m_err = 1'b1; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_idle();
    vc0_valid = 1'b1; vc1_valid = 1'b1; credit_in = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({vc0_ready, vc1_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b want=00", {vc0_ready, vc1_ready});
    end
    checks++;
    if ({flit_valid, vc_sel, flit_out} !== 10'h000) begin
      failures++; $display("FAIL reset_out got=%b/%b/%h want=0/0/00", flit_valid, vc_sel, flit_out);
    end
    checks++;
    if ({vc0_credits, vc1_credits, credit_err} !== {3'd2, 3'd2, 1'b0}) begin
      failures++; $display("FAIL reset_credits got=%0d/%0d err=%b want=2/2 err=0",
                           vc0_credits, vc1_credits, credit_err);
    end
    set_idle();
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_contention_and_resume();
    logic [7:0] exp_f [4];
    logic       exp_s [4];
    logic [7:0] n0;
    logic [7:0] n1;
    exp_f = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
    n0 = 8'h00; n1 = 8'h00;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hA0 + n0, 1'b1, 8'hB0 + n1, 1'b0, 1'b0);
      if (act_r0) n0 = n0 + 8'h01;
      if (act_r1) n1 = n1 + 8'h01;
      checks++;
      if ({flit_valid, vc_sel, flit_out} !== {1'b1, exp_s[i], exp_f[i]}) begin
        failures++; $display("FAIL contention_%0d got=%b/%b/%h want=1/%b/%h",
                             i, flit_valid, vc_sel, flit_out, exp_s[i], exp_f[i]);
      end
    end
    drive(1'b1, 8'hA0 + n0, 1'b1, 8'hB0 + n1, 1'b0, 1'b0);
    checks++;
    if ({flit_valid, act_r0, act_r1, vc0_credits, vc1_credits} !== {3'b000, 3'd0, 3'd0}) begin
      failures++; $display("FAIL starved got=v%b r%b%b c%0d/%0d want=v0 r00 c0/0",
                           flit_valid, act_r0, act_r1, vc0_credits, vc1_credits);
    end
    drive(1'b1, 8'hA2, 1'b1, 8'hB2, 1'b1, 1'b1);
    checks++;
    if ({flit_valid, vc0_credits, vc1_credits} !== {1'b0, 3'd0, 3'd1}) begin
      failures++; $display("FAIL credit_return got=v%b c%0d/%0d want=v0 c0/1",
                           flit_valid, vc0_credits, vc1_credits);
    end
    drive(1'b1, 8'hA2, 1'b1, 8'hB2, 1'b0, 1'b0);
    checks++;
    if ({act_r0, act_r1, flit_valid, vc_sel, flit_out, vc1_credits} !==
        {2'b01, 1'b1, 1'b1, 8'hB2, 3'd0}) begin
      failures++; $display("FAIL resume got=r%b%b v%b s%b %h c1=%0d want=r01 v1 s1 b2 c1=0",
                           act_r0, act_r1, flit_valid, vc_sel, flit_out, vc1_credits);
    end
    drive(1'b1, 8'hA2, 1'b1, 8'hB3, 1'b0, 1'b0);
    checks++;
    if ({flit_valid, vc1_credits, flit_out} !== {1'b0, 3'd0, 8'hB2}) begin
      failures++; $display("FAIL resume_stall got=v%b c1=%0d %h want=v0 c1=0 b2",
                           flit_valid, vc1_credits, flit_out);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h11 + 8'(i), 1'b0, 8'($urandom), 1'b1, 1'b0);
      checks++;
      if ({flit_valid, flit_out, vc0_credits, credit_err} !== {1'b1, 8'h11 + 8'(i), 3'd1, 1'b0}) begin
        failures++; $display("FAIL simul_%0d got=v%b %h c0=%0d err=%b want=v1 %h c0=1 err=0",
                             i, flit_valid, flit_out, vc0_credits, credit_err, 8'h11 + 8'(i));
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if ({vc0_credits, vc1_credits, credit_err} !== {3'd2, 3'd2, 1'b1}) begin
      failures++; $display("FAIL overflow got=%0d/%0d err=%b want=2/2 err=1",
                           vc0_credits, vc1_credits, credit_err);
    end
    for (int i = 0; i < 10; i++) drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (credit_err !== 1'b1) begin
      failures++; $display("FAIL err_sticky got=%b want=1", credit_err);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (credit_err !== 1'b0) begin
      failures++; $display("FAIL err_clear got=%b want=0", credit_err);
    end
    model_reset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_payload();
    do_reset();
    drive(1'b1, 8'h5A, 1'b0, 8'h33, 1'b0, 1'b0);
    drive(1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({act_r0, act_r1, flit_valid, vc_sel, flit_out, vc1_credits} !==
        {2'b01, 1'b1, 1'b1, 8'h00, 3'd1}) begin
      failures++; $display("FAIL zero_payload got=r%b%b v%b s%b %h c1=%0d want=r01 v1 s1 00 c1=1",
                           act_r0, act_r1, flit_valid, vc_sel, flit_out, vc1_credits);
    end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    drive(1'b1, 8'h21, 1'b1, 8'h31, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b1, 8'h31, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({flit_valid, flit_out, vc0_credits, vc1_credits} !== {1'b0, 8'h00, 3'd2, 3'd2}) begin
      failures++; $display("FAIL midreset got=v%b %h c%0d/%0d want=v0 00 c2/2",
                           flit_valid, flit_out, vc0_credits, vc1_credits);
    end
    vc0_valid = 1'b1; vc0_flit = 8'hC0; vc1_valid = 1'b1; vc1_flit = 8'hD0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({flit_valid, vc_sel, flit_out} !== {1'b1, 1'b0, 8'hC0}) begin
      failures++; $display("FAIL post_reset_first got=v%b s%b %h want=v1 s0 c0",
                           flit_valid, vc_sel, flit_out);
    end
    set_idle();
    do_reset();
  endtask

  task automatic test_random();
    logic v0, v1, ci, cv;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      ci = ($urandom_range(0, 2) == 0);
      cv = 1'($urandom_range(0, 1));
      drive(v0, 8'($urandom), v1, 8'($urandom), ci, cv);
      checks++;
      if ({act_r0, act_r1} !== {exp_r0, exp_r1}) begin
        failures++; $display("FAIL rand_ready cyc=%0d got=%b%b want=%b%b",
                             i, act_r0, act_r1, exp_r0, exp_r1);
      end
      checks++;
      if ({flit_valid, vc_sel, flit_out} !== {m_fv, m_sel, m_fo}) begin
        failures++; $display("FAIL rand_out cyc=%0d got=v%b s%b %h want=v%b s%b %h",
                             i, flit_valid, vc_sel, flit_out, m_fv, m_sel, m_fo);
      end
      checks++;
      if ({vc0_credits, vc1_credits, credit_err} !== {3'(m_c0), 3'(m_c1), m_err}) begin
        failures++; $display("FAIL rand_credits cyc=%0d got=%0d/%0d err=%b want=%0d/%0d err=%b",
                             i, vc0_credits, vc1_credits, credit_err, m_c0, m_c1, m_err);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_contention_and_resume();
    test_simultaneous();
    test_overflow();
    test_zero_payload();
    test_midstream_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
